// File: rtl/exec_pkg.sv
// rtl/exec_pkg.sv - shared constants and forwarding helper for the execute stage
package exec_pkg;

    localparam int NCS_DEFAULT        = 16;
    localparam int MUL_CYCLES_DEFAULT = 16;

    // Control bundle bit map
    localparam int CTRL_ALU_OP_LSB = 0;
    localparam int CTRL_ALU_OP_MSB = 3;
    localparam int CTRL_SRC2_IMM   = 4;
    localparam int CTRL_WB_EN      = 5;
    localparam int CTRL_FLAGS_EN   = 8;

    // CCR bit positions: flags are {C,N,Z}
    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;

    // ALU operation codes
    localparam logic [3:0] ALU_NOP  = 4'd0;
    localparam logic [3:0] ALU_MOV  = 4'd1;
    localparam logic [3:0] ALU_ADD  = 4'd2;
    localparam logic [3:0] ALU_SUB  = 4'd3;
    localparam logic [3:0] ALU_AND  = 4'd4;
    localparam logic [3:0] ALU_OR   = 4'd5;
    localparam logic [3:0] ALU_NOT  = 4'd6;
    localparam logic [3:0] ALU_INC  = 4'd7;
    localparam logic [3:0] ALU_DEC  = 4'd8;
    localparam logic [3:0] ALU_SHL  = 4'd9;
    localparam logic [3:0] ALU_SHR  = 4'd10;
    localparam logic [3:0] ALU_MUL  = 4'd11;
    localparam logic [3:0] ALU_SETC = 4'd12;
    localparam logic [3:0] ALU_CLRC = 4'd13;

    // Operand forwarding: the younger EM result beats the older MW result,
    // and either beats the value read from the register file in decode.
    function automatic logic [15:0] fwd_value(
        input logic [3:0]  num,
        input logic [15:0] decode_val,
        input logic        em_wb_en,
        input logic [3:0]  em_dst,
        input logic [15:0] em_val,
        input logic        mw_wb_en,
        input logic [3:0]  mw_dst,
        input logic [15:0] mw_val
    );
        if (em_wb_en && (em_dst == num)) begin
            return em_val;
        end else if (mw_wb_en && (mw_dst == num)) begin
            return mw_val;
        end
        return decode_val;
    endfunction

endpackage

// File: rtl/execute_stage_iter_multiplier.sv
// rtl/execute_stage_iter_multiplier.sv - iterative shift-add multiplier with IDLE/BUSY/DONE FSM
//
// Ports:
//   clk, reset   clock, synchronous active-low reset
//   start_i      request a multiply (sampled in IDLE only)
//   a_i, b_i     operands, latched when the multiply starts
//   busy_o       high in the starting IDLE cycle and every BUSY cycle
//   done_o       high for the single DONE cycle
//   product_o    low WIDTH bits of a*b, valid while done_o
module iter_multiplier
    import exec_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int CYCLES = MUL_CYCLES_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] product_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;

    // Only the low WIDTH product bits are kept, so the multiplicand may
    // shift its upper bits out without affecting the result.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    mcand_d  = a_i;
                    mplier_d = b_i;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(CYCLES - 1)) begin
                    state_d = ST_DONE;
                end
            end
            // The upstream register advances on this edge, so go straight
            // back to IDLE instead of re-sampling the same start request.
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
        end
    end

    assign busy_o    = ((state_q == ST_IDLE) && start_i) || (state_q == ST_BUSY);
    assign done_o    = (state_q == ST_DONE);
    assign product_o = acc_q;

endmodule

// File: rtl/execute_stage.sv
// rtl/execute_stage.sv - EX stage: operand forwarding, 16-bit ALU, CCR and multiply stall control
//
// Ports:
//   clk, reset                 clock, synchronous active-low reset
//   ctrl_i                     control bundle from DE register
//   dst_num_i / dst_val_i      destination number and store data
//   src1_num_i / src1_val_i    source-1 number (3 bits) and decode value
//   src2_num_i / src2_val_i    source-2 number and decode value
//   imm_i                      immediate field
//   em_* / mw_*                write-back info from the EM and MW stages
//   result_o                   ALU or multiplier result
//   store_val_o                forwarded dst value for stores
//   flags_o                    CCR {C,N,Z}
//   ctrl_o                     control to EM register, zero while stalled
//   dst_num_o                  dst_num_i passed through
//   stall_o                    freeze PC, FD and DE registers
module execute_stage
    import exec_pkg::*;
#(
    parameter int NUMBER_CONTROL_SIGNALS = NCS_DEFAULT,
    parameter int MUL_CYCLES             = MUL_CYCLES_DEFAULT
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUMBER_CONTROL_SIGNALS-1:0] ctrl_i,
    input  logic [3:0]                        dst_num_i,
    input  logic [15:0]                       dst_val_i,
    input  logic [2:0]                        src1_num_i,
    input  logic [15:0]                       src1_val_i,
    input  logic [3:0]                        src2_num_i,
    input  logic [15:0]                       src2_val_i,
    input  logic [15:0]                       imm_i,
    input  logic                              em_wb_en_i,
    input  logic [3:0]                        em_dst_i,
    input  logic [15:0]                       em_val_i,
    input  logic                              mw_wb_en_i,
    input  logic [3:0]                        mw_dst_i,
    input  logic [15:0]                       mw_val_i,
    output logic [15:0]                       result_o,
    output logic [15:0]                       store_val_o,
    output logic [2:0]                        flags_o,
    output logic [NUMBER_CONTROL_SIGNALS-1:0] ctrl_o,
    output logic [3:0]                        dst_num_o,
    output logic                              stall_o
);

    logic [3:0]  alu_op;
    logic        src2_imm;
    logic        flags_en;
    logic [15:0] op1, op2, src2_fwd;
    logic [15:0] alu_result;
    logic        c_next;
    logic        zn_upd;
    logic [16:0] sum17;
    logic [31:0] wide;
    logic [3:0]  sh;
    logic [2:0]  ccr_q, ccr_d;
    logic        mul_busy, mul_done;
    logic [15:0] mul_product;

    assign alu_op   = ctrl_i[CTRL_ALU_OP_MSB:CTRL_ALU_OP_LSB];
    assign src2_imm = ctrl_i[CTRL_SRC2_IMM];
    assign flags_en = ctrl_i[CTRL_FLAGS_EN];

    // src1 has only 3 bits, so it can never match r8-r15 on the EM/MW buses.
    assign op1 = fwd_value({1'b0, src1_num_i}, src1_val_i, em_wb_en_i, em_dst_i, em_val_i,
                           mw_wb_en_i, mw_dst_i, mw_val_i);
    assign src2_fwd = fwd_value(src2_num_i, src2_val_i, em_wb_en_i, em_dst_i, em_val_i,
                                mw_wb_en_i, mw_dst_i, mw_val_i);
    assign store_val_o = fwd_value(dst_num_i, dst_val_i, em_wb_en_i, em_dst_i, em_val_i,
                                   mw_wb_en_i, mw_dst_i, mw_val_i);
    assign op2 = src2_imm ? imm_i : src2_fwd;
    assign sh  = op2[3:0];

    iter_multiplier #(
        .WIDTH  (16),
        .CYCLES (MUL_CYCLES)
    ) u_mul (
        .clk       (clk),
        .reset     (reset),
        .start_i   (alu_op == ALU_MUL),
        .a_i       (op1),
        .b_i       (op2),
        .busy_o    (mul_busy),
        .done_o    (mul_done),
        .product_o (mul_product)
    );

    assign stall_o = mul_busy;

    always_comb begin
        alu_result = 16'h0000;
        c_next     = ccr_q[FLAG_C];
        zn_upd     = 1'b0;
        sum17      = 17'h0;
        wide       = 32'h0;
        case (alu_op)
            ALU_MOV: alu_result = op2;
            ALU_ADD: begin
                sum17      = {1'b0, op1} + {1'b0, op2};
                alu_result = sum17[15:0];
                c_next     = sum17[16];
                zn_upd     = 1'b1;
            end
            ALU_SUB: begin
                // Bit 16 of the 17-bit difference is the borrow.
                sum17      = {1'b0, op1} - {1'b0, op2};
                alu_result = sum17[15:0];
                c_next     = sum17[16];
                zn_upd     = 1'b1;
            end
            ALU_AND: begin
                alu_result = op1 & op2;
                zn_upd     = 1'b1;
            end
            ALU_OR: begin
                alu_result = op1 | op2;
                zn_upd     = 1'b1;
            end
            ALU_NOT: begin
                alu_result = ~op1;
                zn_upd     = 1'b1;
            end
            ALU_INC: begin
                sum17      = {1'b0, op1} + 17'd1;
                alu_result = sum17[15:0];
                c_next     = sum17[16];
                zn_upd     = 1'b1;
            end
            ALU_DEC: begin
                sum17      = {1'b0, op1} - 17'd1;
                alu_result = sum17[15:0];
                c_next     = sum17[16];
                zn_upd     = 1'b1;
            end
            ALU_SHL: begin
                // Bit 16 of the widened shift is the last bit pushed out.
                wide       = {16'h0000, op1} << sh;
                alu_result = wide[15:0];
                if (sh != 4'd0) begin
                    c_next = wide[16];
                end
                zn_upd     = 1'b1;
            end
            ALU_SHR: begin
                wide       = {op1, 16'h0000} >> sh;
                alu_result = wide[31:16];
                if (sh != 4'd0) begin
                    c_next = wide[15];
                end
                zn_upd     = 1'b1;
            end
            ALU_MUL: begin
                alu_result = mul_done ? mul_product : 16'h0000;
                zn_upd     = 1'b1;
            end
            ALU_SETC: c_next = 1'b1;
            ALU_CLRC: c_next = 1'b0;
            default: ;
        endcase
    end

    always_comb begin
        ccr_d = ccr_q;
        if (flags_en && !stall_o) begin
            ccr_d[FLAG_C] = c_next;
            if (zn_upd) begin
                ccr_d[FLAG_Z] = (alu_result == 16'h0000);
                ccr_d[FLAG_N] = alu_result[15];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ccr_q <= 3'b000;
        end else begin
            ccr_q <= ccr_d;
        end
    end

    assign result_o  = alu_result;
    assign flags_o   = ccr_q;
    assign ctrl_o    = stall_o ? '0 : ctrl_i;
    assign dst_num_o = dst_num_i;

endmodule
